// File: rtl/switch_pulse_sequencer.sv
// rtl/switch_pulse_sequencer.sv - set/reset pulse sequencer for one latching photonic switch
//
// Accepts one state-change request at a time, drives a single PWMset or
// PWMreset pulse lasting A_val/B_val qualified ticks, then waits SETTLE
// qualified ticks before it will accept the next request.
//
// Ports:
//   clk        core clock
//   reset      asynchronous active-high reset
//   en         global enable; low freezes state, counter and outputs
//   tick       single-cycle timing strobe; all intervals are counted in ticks
//   A_val      set-pulse length in ticks (sampled at acceptance)
//   B_val      reset-pulse length in ticks (sampled at acceptance)
//   req_valid  state-change request
//   req_state  requested switch state (1 = set, 0 = reset)
//   req_ready  request can be accepted this cycle (combinational)
//   PWMset     set-coil drive (registered)
//   PWMreset   reset-coil drive (registered)
//   sw_state   last commanded switch state (registered)
//   busy       high whenever the sequencer is not idle (registered)
//   done       one-cycle strobe on return to idle (registered)
module switch_pulse_sequencer #(
  parameter int W      = 7,
  parameter int SETTLE = 24
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         tick,
  input  logic [W-1:0] A_val,
  input  logic [W-1:0] B_val,
  input  logic         req_valid,
  input  logic         req_state,
  output logic         req_ready,
  output logic         PWMset,
  output logic         PWMreset,
  output logic         sw_state,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SET_PULSE,
    ST_RESET_PULSE,
    ST_SETTLE
  } state_t;

  localparam logic [W-1:0] SETTLE_CNT = W'(SETTLE);
  localparam logic [W-1:0] CNT_ONE    = W'(1);

  state_t       state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic         target_q, target_d;
  logic         sw_state_q, sw_state_d;
  logic         pwm_set_q, pwm_set_d;
  logic         pwm_reset_q, pwm_reset_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic [W-1:0] sel_len;

  assign req_ready = (state_q == ST_IDLE) & en;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    target_d   = target_q;
    sw_state_d = sw_state_q;
    done_d     = done_q;
    sel_len    = req_state ? A_val : B_val;

    // With en low every register, done included, keeps its value.
    if (en) begin
      done_d = 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            target_d = req_state;
            if (sel_len == '0) begin
              // Zero-length pulse: nothing to drive, go straight to settling.
              sw_state_d = req_state;
              cnt_d      = SETTLE_CNT;
              state_d    = ST_SETTLE;
            end else begin
              cnt_d   = sel_len;
              state_d = req_state ? ST_SET_PULSE : ST_RESET_PULSE;
            end
          end
        end
        ST_SET_PULSE, ST_RESET_PULSE: begin
          if (tick) begin
            if (cnt_q == CNT_ONE) begin
              sw_state_d = target_q;
              cnt_d      = SETTLE_CNT;
              state_d    = ST_SETTLE;
            end else begin
              cnt_d = cnt_q - CNT_ONE;
            end
          end
        end
        ST_SETTLE: begin
          if (tick) begin
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Drive outputs are decoded from the next state so they are registered
    // and can never both be high.
    pwm_set_d   = (state_d == ST_SET_PULSE);
    pwm_reset_d = (state_d == ST_RESET_PULSE);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      target_q    <= 1'b0;
      sw_state_q  <= 1'b0;
      pwm_set_q   <= 1'b0;
      pwm_reset_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      target_q    <= target_d;
      sw_state_q  <= sw_state_d;
      pwm_set_q   <= pwm_set_d;
      pwm_reset_q <= pwm_reset_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign PWMset   = pwm_set_q;
  assign PWMreset = pwm_reset_q;
  assign sw_state = sw_state_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_switch_pulse_sequencer.sv
// tb/tb_switch_pulse_sequencer.sv - self-checking bench for switch_pulse_sequencer
module tb_switch_pulse_sequencer;

  localparam int W      = 7;
  localparam int SETTLE = 24;
  localparam int NMAX   = 700;

  logic         clk;
  logic         reset;
  logic         en;
  logic         tick;
  logic [W-1:0] A_val;
  logic [W-1:0] B_val;
  logic         req_valid;
  logic         req_state;
  logic         req_ready;
  logic         PWMset;
  logic         PWMreset;
  logic         sw_state;
  logic         busy;
  logic         done;

  switch_pulse_sequencer #(.W(W), .SETTLE(SETTLE)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .tick      (tick),
    .A_val     (A_val),
    .B_val     (B_val),
    .req_valid (req_valid),
    .req_state (req_state),
    .req_ready (req_ready),
    .PWMset    (PWMset),
    .PWMreset  (PWMreset),
    .sw_state  (sw_state),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus per posedge index e (value present at edge e).
  bit           en_a   [0:NMAX+1];
  bit           tick_a [0:NMAX+1];
  bit           rv_a   [0:NMAX+1];
  bit           rs_a   [0:NMAX+1];
  logic [W-1:0] a_a    [0:NMAX+1];
  logic [W-1:0] b_a    [0:NMAX+1];

  // Expected outputs after edge k (k = 0 is straight after reset).
  bit exp_set  [0:NMAX+1];
  bit exp_rst  [0:NMAX+1];
  bit exp_sw   [0:NMAX+1];
  bit exp_busy [0:NMAX+1];
  bit exp_done [0:NMAX+1];

  int checks;
  int errors;
  int set_hi;
  int rst_hi;
  int done_cnt;

  task automatic chk(input string tag, input int obs, input int expv, input int k);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s at edge %0d: observed %0d expected %0d", tag, k, obs, expv);
    end
  endtask

  task automatic gen(input int n, input int period, input int phase,
                     input int en_off, input int rv_pct, input int lmax);
    for (int e = 0; e <= n + 1; e++) begin
      tick_a[e] = ((e + phase) % period) == 0;
      en_a[e]   = ($urandom_range(99, 0) >= en_off);
      rv_a[e]   = ($urandom_range(99, 0) < rv_pct);
      rs_a[e]   = 1'($urandom_range(1, 0));
      a_a[e]    = W'($urandom_range(lmax, 0));
      b_a[e]    = W'($urandom_range(lmax, 0));
    end
  endtask

  // Edge of the cnt-th qualified tick strictly after edge 'from'; n+1 if none.
  function automatic int next_qual(input int from, input int cnt, input int n);
    int c;
    c = 0;
    for (int e = from + 1; e <= n; e++) begin
      if (en_a[e] && tick_a[e]) begin
        c++;
        if (c == cnt) return e;
      end
    end
    return n + 1;
  endfunction

  // Transaction-level prediction: find each acceptance edge, then locate the
  // pulse end and settle end by counting qualified ticks.
  task automatic build_model(input int n);
    int from, a, e1, e2, len;
    bit st;
    for (int k = 0; k <= n; k++) begin
      exp_set[k] = 0; exp_rst[k] = 0; exp_sw[k] = 0; exp_busy[k] = 0; exp_done[k] = 0;
    end
    from = 0;
    while (from <= n) begin
      a = -1;
      for (int e = from + 1; e <= n; e++) begin
        if (en_a[e] && rv_a[e]) begin a = e; break; end
      end
      if (a < 0) break;
      st  = rs_a[a];
      len = st ? int'(a_a[a]) : int'(b_a[a]);
      e1  = (len == 0) ? a : next_qual(a, len, n);
      for (int k = a; k < e1 && k <= n; k++) begin
        if (st) exp_set[k] = 1; else exp_rst[k] = 1;
      end
      for (int k = e1; k <= n; k++) exp_sw[k] = st;
      e2 = next_qual(e1, SETTLE, n);
      for (int k = a; k < e2 && k <= n; k++) exp_busy[k] = 1;
      for (int k = e2; k <= n; k++) begin
        if (k != e2 && en_a[k]) break;
        exp_done[k] = 1;
      end
      from = e2;
    end
  endtask

  task automatic drive(input int k);
    en        = en_a[k];
    tick      = tick_a[k];
    req_valid = rv_a[k];
    req_state = rs_a[k];
    A_val     = a_a[k];
    B_val     = b_a[k];
  endtask

  task automatic check_outputs(input int k);
    chk("pwm_set",   int'(PWMset),   int'(exp_set[k]),  k);
    chk("pwm_reset", int'(PWMreset), int'(exp_rst[k]),  k);
    chk("sw_state",  int'(sw_state), int'(exp_sw[k]),   k);
    chk("busy",      int'(busy),     int'(exp_busy[k]), k);
    chk("done",      int'(done),     int'(exp_done[k]), k);
    chk("pwm_excl",  int'(PWMset & PWMreset), 0, k);
    if (PWMset)   set_hi++;
    if (PWMreset) rst_hi++;
    if (done)     done_cnt++;
  endtask

  task automatic run_segment(input int n);
    build_model(n);
    set_hi = 0; rst_hi = 0; done_cnt = 0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_outputs(0);
    set_hi = 0; rst_hi = 0; done_cnt = 0;
    reset = 1'b0;
    drive(1);
    #1;
    chk("req_ready", int'(req_ready), int'(en_a[1] & ~exp_busy[0]), 0);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      check_outputs(k);
      if (k < n) begin
        drive(k + 1);
        #1;
        chk("req_ready", int'(req_ready), int'(en_a[k+1] & ~exp_busy[k]), k);
      end
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    reset = 1'b1; en = 1'b0; tick = 1'b0; req_valid = 1'b0; req_state = 1'b0;
    A_val = '0; B_val = '0;

    // Set pulse of 2 ticks, tick every 8 clocks.
    gen(320, 8, 0, 0, 0, 0);
    rv_a[2] = 1; rs_a[2] = 1; a_a[2] = 2;
    run_segment(320);
    chk("t1_set_high_cycles_in_9_16", int'(set_hi >= 9 && set_hi <= 16), 1, 320);
    chk("t1_done_strobes", done_cnt, 1, 320);

    // Set, then reset of 15 ticks with req_valid held from mid-settle.
    gen(540, 8, 0, 0, 0, 0);
    rv_a[2] = 1; rs_a[2] = 1; a_a[2] = 2;
    for (int e = 40; e <= 300; e++) begin
      rv_a[e] = 1; rs_a[e] = 0; b_a[e] = 15;
    end
    run_segment(540);
    chk("t2_reset_high_cycles_in_113_120", int'(rst_hi >= 113 && rst_hi <= 120), 1, 540);
    chk("t2_done_strobes", done_cnt, 2, 540);

    // Zero-length set request.
    gen(230, 8, 0, 0, 0, 0);
    rv_a[2] = 1; rs_a[2] = 1; a_a[2] = 0;
    run_segment(230);
    chk("t4_no_set_pulse", set_hi, 0, 230);
    chk("t4_done_strobes", done_cnt, 1, 230);

    // en dropped for 15 cycles while PWMset is high.
    gen(260, 8, 0, 0, 0, 0);
    rv_a[2] = 1; rs_a[2] = 1; a_a[2] = 2;
    for (int e = 5; e <= 19; e++) en_a[e] = 0;
    run_segment(260);
    chk("t5_set_high_cycles", set_hi, 30, 260);

    // Asynchronous reset in the middle of a reset pulse.
    gen(70, 2, 0, 0, 0, 0);
    rv_a[2] = 1; rs_a[2] = 1; a_a[2] = 1;
    rv_a[53] = 1; rs_a[53] = 0; b_a[53] = 15;
    run_segment(70);
    #2 reset = 1'b1;
    #1;
    chk("t6_async_pwmreset", int'(PWMreset), 0, 70);
    chk("t6_async_sw_state", int'(sw_state), 0, 70);
    chk("t6_async_busy",     int'(busy),     0, 70);

    // Request accepted on the first edge after reset release.
    gen(60, 3, 0, 0, 0, 10);
    rv_a[1] = 1; rs_a[1] = 0; b_a[1] = 5;
    run_segment(60);

    // Maximum pulse length with a tick every cycle.
    gen(170, 1, 0, 0, 0, 0);
    rv_a[1] = 1; rs_a[1] = 1; a_a[1] = 7'd127;
    run_segment(170);
    chk("max_len_set_cycles", set_hi, 127, 170);

    // Randomized traffic.
    for (int s = 0; s < 8; s++) begin
      gen(600, int'($urandom_range(4, 1)), int'($urandom_range(3, 0)), 10, 25, 20);
      run_segment(600);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/switch_pulse_sequencer.md
# switch_pulse_sequencer

Sequences set/reset drive pulses for one latching photonic switch. It accepts one state-change request at a time and drives a single PWMset or PWMreset pulse whose length, in ticks, comes from the programmed A_val/B_val. It then enforces a settling interval before accepting the next request. It sits between the host configuration logic and the switch driver pins, and counts on the design's slow clock-enable tick (en_1MHz).

## Interface
- W, 7, width of pulse-length values and the pulse counter
- SETTLE, 24, settling interval in ticks after each pulse (1..2^W-1)
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- en  in  1  global enable; low freezes the block
- tick  in  1  single-cycle clock-enable strobe (en_1MHz); all timing is counted in ticks
- A_val  in  W  set-pulse length in ticks
- B_val  in  W  reset-pulse length in ticks
- req_valid  in  1  state-change request
- req_state  in  1  requested switch state (1 = set, 0 = reset)
- req_ready  out  1  request can be accepted this cycle
- PWMset  out  1  set-coil drive
- PWMreset  out  1  reset-coil drive
- sw_state  out  1  last commanded switch state
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle strobe when the sequence returns to IDLE

## Operation
- Four states: IDLE, SET_PULSE, RESET_PULSE, SETTLE. There is one W-bit down-counter, cnt.
- req_ready = (state == IDLE) & en. It is combinational.
- Acceptance occurs on an edge where req_valid & req_ready are both high.
  - The length is taken from A_val if req_state = 1, otherwise from B_val, and loaded into cnt. The A_val/B_val sampled at acceptance are used; later changes have no effect on a pulse in progress.
  - Next state is SET_PULSE or RESET_PULSE respectively.
  - If the selected length is 0: no pulse is driven, sw_state updates immediately, the next state is SETTLE, and cnt is loaded with SETTLE.
- In SET_PULSE or RESET_PULSE, PWMset or PWMreset is high respectively.
  - On each edge with en & tick, cnt decrements.
  - On the edge where en & tick and cnt == 1: sw_state takes req_state, cnt loads SETTLE, and the next state is SETTLE.
- In SETTLE, cnt decrements on each en & tick. When en & tick and cnt == 1, the next state is IDLE and done pulses for one cycle.
- A request held during busy is not accepted. It is accepted on the first cycle in IDLE with en high, which can be the cycle right after done.
- Redundant requests (req_state == sw_state) execute the full pulse and settle. No suppression.
- en low:
  - state, cnt, and all outputs hold their values, so an active pulse stays high.
  - tick is ignored.
  - req_ready is 0.
- Invariant: PWMset & PWMreset is never 1.

## Timing
- Reset values: state IDLE, cnt 0, PWMset 0, PWMreset 0, sw_state 0, busy 0, done 0. req_ready follows en.
- Reset is asynchronous and takes effect mid-pulse. The drive output drops immediately without waiting for a clock edge, and sw_state returns to 0.
- All outputs except req_ready are registered.
- Pulse start: the drive output goes high in the cycle after the acceptance edge.
- Pulse length:
  - The pulse covers exactly L qualified ticks, where L = selected length. It ends on the edge that samples the L-th tick.
  - A tick coincident with the acceptance edge is not counted.
  - With a tick period of P cycles, the high time is between (L-1)·P+1 and L·P cycles, depending on tick phase.
- Settle: SETTLE qualified ticks, counted from the first tick after the pulse ends. done is asserted on the edge that samples the last of these ticks.
- Wrap: the maximum length 2^W-1 is legal. cnt never underflows, because 0 is only loaded in IDLE.

## Test plan
- tick every 8 clk, A_val=2, request set -> PWMset high for 2 ticks (9..16 cycles); sw_state=1 at pulse end; busy through 24 settle ticks; one done strobe; req_ready high on the next cycle.
- B_val=15, request reset while sw_state=1 -> PWMreset high for 15 ticks; PWMset stays 0 throughout; sw_state=0 at pulse end.
- req_valid held high from mid-settle -> no acceptance until IDLE; the second pulse starts in the cycle after done+1; no lost or duplicated pulse.
- A_val=0, request set -> PWMset never high; sw_state=1 on the cycle after acceptance; done after exactly 24 ticks.
- en dropped for 15 cycles during PWMset -> PWMset stays high and ticks are ignored; the total counted ticks still equal 2 after en returns.
- reset asserted mid-PWMreset -> PWMreset low with no clock edge; sw_state=0, busy=0; a new request is accepted after release with en high.
